ddr2_client_master: RTL

//  Initiator for the controller's client request port (c_addr/c_data_in/c_rd_req/c_wr_req/c_rdy/c_data_out).
//  On start it writes NUM_WORDS pseudo-random 64-bit words from START_ADDR, then reads them back and compares.

---
 rtl/ddr2_client_master_pkg.sv | 31 +++
 rtl/ddr2_client_master_lfsr64.sv | 37 +++
 rtl/ddr2_client_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ddr2_client_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ddr2_client_master_pkg
// Brief   : Shared types and constants for the DDR2 client-port traffic
//           master: FSM state encoding and the 64-bit Galois LFSR step.
// Revision: 1.0 - initial release
// ============================================================================
package ddr2_client_master_pkg;

    // Request sequencer states; GAP states give the single idle cycle
    // between consecutive requests.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_GAP  = 3'd2,
        ST_RD_SEED = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_GAP  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Right-shifting Galois form of taps 64,63,61,60 (bit indices 63,62,60,59).
    localparam logic [63:0] C_LFSR_TAPS = 64'hD800_0000_0000_0000;

    // One LFSR step; a nonzero state never maps to zero.
    function automatic logic [63:0] lfsr64_next(input logic [63:0] s);
        return {1'b0, s[63:1]} ^ (s[0] ? C_LFSR_TAPS : 64'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr2_client_master_lfsr64.sv
`default_nettype none
// ============================================================================
// Module  : ddr2_client_master_lfsr64
// Brief   : 64-bit Galois LFSR with synchronous reload to SEED and an
//           advance strobe. Generates both the write data and the read
//           expectation stream.
// Revision: 1.0 - initial release
// ============================================================================
module ddr2_client_master_lfsr64
    import ddr2_client_master_pkg::*;
#(
    parameter logic [63:0] SEED = 64'hACE1_0000_0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [63:0] o_state
);

    logic [63:0] r_state;

    // Reload has priority so a restart always replays from SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_advance) begin
            r_state <= lfsr64_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/ddr2_client_master.sv
`default_nettype none
// ============================================================================
// Module  : ddr2_client_master
// Brief   : Client-port traffic master. Writes NUM_WORDS LFSR words from
//           START_ADDR, replays the LFSR to read and compare them, and
//           reports pass / timeout / error count / first failing address.
// Revision: 1.0 - initial release
// ============================================================================
module ddr2_client_master
    import ddr2_client_master_pkg::*;
#(
    parameter int                ADDR_W     = 26,
    parameter int                DATA_W     = 64,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                ADDR_INC   = 4,
    parameter int                NUM_WORDS  = 16,
    parameter logic [63:0]       SEED       = 64'hACE1_0000_0000_0001,
    parameter int                TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data_in,
    output logic              c_wr_req,
    output logic              c_rd_req,
    input  logic              c_rdy,
    input  logic [DATA_W-1:0] c_data_out
);

    localparam int                TW         = $clog2(TIMEOUT + 1);
    localparam logic [15:0]       C_LAST     = 16'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] C_ADDR_INC = ADDR_W'(ADDR_INC);
    localparam logic [TW-1:0]     C_TO_LAST  = TW'(TIMEOUT - 1);

    state_t          r_state;
    logic [15:0]     r_word_cnt;
    logic [TW-1:0]   r_timer;
    logic [63:0]     w_lfsr;
    logic            w_start_acc;
    logic            w_accept;
    logic            w_lfsr_load;
    logic            w_mismatch;

    assign w_start_acc = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_accept    = (c_wr_req || c_rd_req) && c_rdy;
    assign w_lfsr_load = w_start_acc || (r_state == ST_RD_SEED);
    assign w_mismatch  = c_data_out != w_lfsr;

    ddr2_client_master_lfsr64 #(
        .SEED      (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_lfsr_load),
        .i_advance (w_accept),
        .o_state   (w_lfsr)
    );

    // Request sequencer: owns every registered output, counters and checks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_timer    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_count  <= '0;
            first_err  <= '0;
            c_addr     <= '0;
            c_data_in  <= '0;
            c_wr_req   <= 1'b0;
            c_rd_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_WR_REQ;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        err_count  <= '0;
                        first_err  <= '0;
                        c_wr_req   <= 1'b1;
                        c_addr     <= START_ADDR;
                        // LFSR reloads on this same edge, so present SEED directly.
                        c_data_in  <= DATA_W'(SEED);
                        r_word_cnt <= '0;
                        r_timer    <= '0;
                    end
                end
                ST_WR_REQ: begin
                    if (c_rdy) begin
                        c_wr_req   <= 1'b0;
                        r_word_cnt <= r_word_cnt + 16'd1;
                        r_state    <= ST_WR_GAP;
                    end else if (r_timer == C_TO_LAST) begin
                        c_wr_req   <= 1'b0;
                        r_state    <= ST_DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        timeout    <= 1'b1;
                        pass       <= 1'b0;
                    end else begin
                        r_timer    <= r_timer + 1'b1;
                    end
                end
                ST_WR_GAP: begin
                    if (r_word_cnt == C_LAST) begin
                        r_state    <= ST_RD_SEED;
                    end else begin
                        c_wr_req   <= 1'b1;
                        c_addr     <= c_addr + C_ADDR_INC;
                        c_data_in  <= DATA_W'(w_lfsr);
                        r_timer    <= '0;
                        r_state    <= ST_WR_REQ;
                    end
                end
                ST_RD_SEED: begin
                    c_rd_req   <= 1'b1;
                    c_addr     <= START_ADDR;
                    r_word_cnt <= '0;
                    r_timer    <= '0;
                    r_state    <= ST_RD_REQ;
                end
                ST_RD_REQ: begin
                    if (c_rdy) begin
                        c_rd_req   <= 1'b0;
                        r_word_cnt <= r_word_cnt + 16'd1;
                        r_state    <= ST_RD_GAP;
                        if (w_mismatch) begin
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                            // err_count never returns to zero, so this fires once.
                            if (err_count == 16'd0) begin
                                first_err <= c_addr;
                            end
                        end
                    end else if (r_timer == C_TO_LAST) begin
                        c_rd_req   <= 1'b0;
                        r_state    <= ST_DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        timeout    <= 1'b1;
                        pass       <= 1'b0;
                    end else begin
                        r_timer    <= r_timer + 1'b1;
                    end
                end
                ST_RD_GAP: begin
                    if (r_word_cnt == C_LAST) begin
                        r_state    <= ST_DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        pass       <= (err_count == 16'd0);
                    end else begin
                        c_rd_req   <= 1'b1;
                        c_addr     <= c_addr + C_ADDR_INC;
                        r_timer    <= '0;
                        r_state    <= ST_RD_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
